// File: rtl/id_ex_latch_if.sv
// Decode-to-execute latch bus.
//   Decode side (master drives): in_valid, SrcReg1/2, use1/2, SrcData1/2,
//     DstReg_id, RegWrite_id, MemRead_id, imm_id, plus writeback
//     (wb_WriteReg/wb_DstReg/wb_DstData) and pipeline control (stall_in, flush).
//   Latch side (slave drives): ex_* execute-stage fields, stall_id, bubble_cnt.
interface id_ex_latch_if #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic [REG_BITS-1:0] SrcReg1;
  logic [REG_BITS-1:0] SrcReg2;
  logic                use1;
  logic                use2;
  logic [WIDTH-1:0]    SrcData1;
  logic [WIDTH-1:0]    SrcData2;
  logic [REG_BITS-1:0] DstReg_id;
  logic                RegWrite_id;
  logic                MemRead_id;
  logic [WIDTH-1:0]    imm_id;
  logic                wb_WriteReg;
  logic [REG_BITS-1:0] wb_DstReg;
  logic [WIDTH-1:0]    wb_DstData;
  logic                stall_in;
  logic                flush;

  logic                ex_valid;
  logic [WIDTH-1:0]    ex_A;
  logic [WIDTH-1:0]    ex_B;
  logic [REG_BITS-1:0] ex_SrcReg1;
  logic [REG_BITS-1:0] ex_SrcReg2;
  logic [REG_BITS-1:0] ex_DstReg;
  logic                ex_RegWrite;
  logic                ex_MemRead;
  logic [WIDTH-1:0]    ex_imm;
  logic                stall_id;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output in_valid, SrcReg1, SrcReg2, use1, use2, SrcData1, SrcData2,
           DstReg_id, RegWrite_id, MemRead_id, imm_id,
           wb_WriteReg, wb_DstReg, wb_DstData, stall_in, flush,
    input  ex_valid, ex_A, ex_B, ex_SrcReg1, ex_SrcReg2, ex_DstReg,
           ex_RegWrite, ex_MemRead, ex_imm, stall_id, bubble_cnt
  );

  modport slave (
    input  in_valid, SrcReg1, SrcReg2, use1, use2, SrcData1, SrcData2,
           DstReg_id, RegWrite_id, MemRead_id, imm_id,
           wb_WriteReg, wb_DstReg, wb_DstData, stall_in, flush,
    output ex_valid, ex_A, ex_B, ex_SrcReg1, ex_SrcReg2, ex_DstReg,
           ex_RegWrite, ex_MemRead, ex_imm, stall_id, bubble_cnt
  );
endinterface

// File: rtl/id_ex_latch.sv
// Decode-to-execute pipeline latch.
// Captures register-file read data and decode control, presenting them to
// execute one cycle later. Bypasses a same-cycle writeback (the register file
// has no write-through), detects load-use hazards and inserts one bubble,
// holds on downstream stall (refreshing held operands from writeback), squashes
// on flush, and keeps a saturating count of load-use bubbles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset (clears every ex_* field and bubble_cnt)
//   bus  - id_ex_latch_if.slave: decode/writeback/control in, ex_*/stall_id/bubble_cnt out
module id_ex_latch #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_latch_if.slave bus
);

  logic [WIDTH-1:0] byp1;
  logic [WIDTH-1:0] byp2;
  logic             luse;
  logic             hit1Hold;
  logic             hit2Hold;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Decode stage: writeback bypass and hazard detection
  always_comb begin
    byp1 = bus.SrcData1;
    byp2 = bus.SrcData2;
    if (bus.wb_WriteReg && (bus.wb_DstReg == bus.SrcReg1)) byp1 = bus.wb_DstData;
    if (bus.wb_WriteReg && (bus.wb_DstReg == bus.SrcReg2)) byp2 = bus.wb_DstData;
  end

  // Only a load that will write a register can create the hazard; the
  // consumer must actually read the matching specifier.
  assign luse = bus.in_valid && bus.ex_valid && bus.ex_MemRead && bus.ex_RegWrite &&
                ((bus.use1 && (bus.ex_DstReg == bus.SrcReg1)) ||
                 (bus.use2 && (bus.ex_DstReg == bus.SrcReg2)));

  assign bus.stall_id = !bus.flush && (bus.stall_in || luse);

  // While held, the operands would otherwise go stale if their source
  // register is written back during the stall.
  assign hit1Hold = bus.ex_valid && bus.wb_WriteReg && (bus.wb_DstReg == bus.ex_SrcReg1);
  assign hit2Hold = bus.ex_valid && bus.wb_WriteReg && (bus.wb_DstReg == bus.ex_SrcReg2);

  // Execute stage boundary: control fields and bubble counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
      bus.bubble_cnt  <= '0;
    end else if (bus.flush) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
    end else if (bus.stall_in) begin
      bus.ex_valid    <= bus.ex_valid;
    end else if (luse) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_RegWrite <= 1'b0;
      bus.ex_MemRead  <= 1'b0;
      bus.bubble_cnt  <= satInc(bus.bubble_cnt);
    end else begin
      bus.ex_valid    <= bus.in_valid;
      bus.ex_RegWrite <= bus.in_valid && bus.RegWrite_id;
      bus.ex_MemRead  <= bus.in_valid && bus.MemRead_id;
    end
  end

  // Execute stage boundary: operand and specifier fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_A       <= '0;
      bus.ex_B       <= '0;
      bus.ex_SrcReg1 <= '0;
      bus.ex_SrcReg2 <= '0;
      bus.ex_DstReg  <= '0;
      bus.ex_imm     <= '0;
    end else if (!bus.flush) begin
      if (bus.stall_in) begin
        if (hit1Hold) bus.ex_A <= bus.wb_DstData;
        if (hit2Hold) bus.ex_B <= bus.wb_DstData;
      end else if (!luse) begin
        bus.ex_A       <= byp1;
        bus.ex_B       <= byp2;
        bus.ex_SrcReg1 <= bus.SrcReg1;
        bus.ex_SrcReg2 <= bus.SrcReg2;
        bus.ex_DstReg  <= bus.DstReg_id;
        bus.ex_imm     <= bus.imm_id;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_latch_if #(.WIDTH(16), .REG_BITS(4), .CNT_W(16)) ifc ();
  id_ex_latch_if #(.WIDTH(16), .REG_BITS(4), .CNT_W(4))  ifS ();

  id_ex_latch #(.WIDTH(16), .REG_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave));
  id_ex_latch #(.WIDTH(16), .REG_BITS(4), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .bus(ifS.slave));

  assign ifS.in_valid    = ifc.in_valid;
  assign ifS.SrcReg1     = ifc.SrcReg1;
  assign ifS.SrcReg2     = ifc.SrcReg2;
  assign ifS.use1        = ifc.use1;
  assign ifS.use2        = ifc.use2;
  assign ifS.SrcData1    = ifc.SrcData1;
  assign ifS.SrcData2    = ifc.SrcData2;
  assign ifS.DstReg_id   = ifc.DstReg_id;
  assign ifS.RegWrite_id = ifc.RegWrite_id;
  assign ifS.MemRead_id  = ifc.MemRead_id;
  assign ifS.imm_id      = ifc.imm_id;
  assign ifS.wb_WriteReg = ifc.wb_WriteReg;
  assign ifS.wb_DstReg   = ifc.wb_DstReg;
  assign ifS.wb_DstData  = ifc.wb_DstData;
  assign ifS.stall_in    = ifc.stall_in;
  assign ifS.flush       = ifc.flush;

  typedef struct {
    logic inV; logic [3:0] s1; logic [3:0] s2; logic u1; logic u2;
    logic [15:0] d1; logic [15:0] d2; logic [3:0] dst; logic rw; logic mr;
    logic [15:0] imm; logic wbW; logic [3:0] wbD; logic [15:0] wbData;
    logic stallIn; logic flush;
  } stim_t;

  typedef struct {
    logic valid; logic [15:0] a; logic [15:0] b; logic [3:0] s1; logic [3:0] s2;
    logic [3:0] dst; logic rw; logic mr; logic [15:0] imm; int cnt;
  } mst_t;

  typedef struct { logic stall; mst_t st; } rec_t;

  rec_t q[$];
  mst_t mdl;
  int nCmp = 0;
  int nFail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mst_t resetState();
    mst_t r;
    r.valid = 0; r.a = 0; r.b = 0; r.s1 = 0; r.s2 = 0;
    r.dst = 0; r.rw = 0; r.mr = 0; r.imm = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.inV = 0; s.s1 = 0; s.s2 = 0; s.u1 = 0; s.u2 = 0; s.d1 = 0; s.d2 = 0;
    s.dst = 0; s.rw = 0; s.mr = 0; s.imm = 0; s.wbW = 0; s.wbD = 0;
    s.wbData = 0; s.stallIn = 0; s.flush = 0;
    return s;
  endfunction

  // Reference: what the execute stage should see after one edge
  function automatic mst_t model(input mst_t c, input stim_t s, output logic stl);
    mst_t n;
    logic hazard;
    n = c;
    hazard = s.inV && c.valid && c.mr && c.rw &&
             ((s.u1 && c.dst == s.s1) || (s.u2 && c.dst == s.s2));
    stl = !s.flush && (s.stallIn || hazard);
    if (s.flush) begin
      n.valid = 0; n.rw = 0; n.mr = 0;
    end else if (s.stallIn) begin
      if (c.valid && s.wbW && s.wbD == c.s1) n.a = s.wbData;
      if (c.valid && s.wbW && s.wbD == c.s2) n.b = s.wbData;
    end else if (hazard) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.cnt = c.cnt + 1;
    end else begin
      n.valid = s.inV;
      n.a = (s.wbW && s.wbD == s.s1) ? s.wbData : s.d1;
      n.b = (s.wbW && s.wbD == s.s2) ? s.wbData : s.d2;
      n.s1 = s.s1; n.s2 = s.s2; n.dst = s.dst; n.imm = s.imm;
      n.rw = s.inV && s.rw; n.mr = s.inV && s.mr;
    end
    return n;
  endfunction

  task automatic drive(input stim_t s);
    ifc.in_valid = s.inV; ifc.SrcReg1 = s.s1; ifc.SrcReg2 = s.s2;
    ifc.use1 = s.u1; ifc.use2 = s.u2; ifc.SrcData1 = s.d1; ifc.SrcData2 = s.d2;
    ifc.DstReg_id = s.dst; ifc.RegWrite_id = s.rw; ifc.MemRead_id = s.mr;
    ifc.imm_id = s.imm; ifc.wb_WriteReg = s.wbW; ifc.wb_DstReg = s.wbD;
    ifc.wb_DstData = s.wbData; ifc.stall_in = s.stallIn; ifc.flush = s.flush;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic step(input stim_t s, output logic stallSeen);
    rec_t r;
    #1;
    drive(s);
    r.st = model(mdl, s, r.stall);
    mdl = r.st;
    q.push_back(r);
    #1 stallSeen = ifc.stall_id;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rndReg();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  function automatic stim_t rndStim();
    stim_t s;
    s.inV = ($urandom_range(0, 7) != 0); s.s1 = rndReg(); s.s2 = rndReg();
    s.u1 = 1'($urandom); s.u2 = 1'($urandom);
    s.d1 = 16'($urandom); s.d2 = 16'($urandom); s.dst = rndReg();
    s.rw = ($urandom_range(0, 3) != 0); s.mr = 1'($urandom); s.imm = 16'($urandom);
    s.wbW = 1'($urandom); s.wbD = rndReg(); s.wbData = 16'($urandom);
    s.stallIn = ($urandom_range(0, 4) == 0); s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: compares stall_id mid-cycle, then the latched state after the edge
  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("stall_id", 32'(ifc.stall_id), 32'(r.stall));
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ifc.ex_valid), 32'(r.st.valid));
        chk("ex_A", 32'(ifc.ex_A), 32'(r.st.a));
        chk("ex_B", 32'(ifc.ex_B), 32'(r.st.b));
        chk("ex_SrcReg1", 32'(ifc.ex_SrcReg1), 32'(r.st.s1));
        chk("ex_SrcReg2", 32'(ifc.ex_SrcReg2), 32'(r.st.s2));
        chk("ex_DstReg", 32'(ifc.ex_DstReg), 32'(r.st.dst));
        chk("ex_RegWrite", 32'(ifc.ex_RegWrite), 32'(r.st.rw));
        chk("ex_MemRead", 32'(ifc.ex_MemRead), 32'(r.st.mr));
        chk("ex_imm", 32'(ifc.ex_imm), 32'(r.st.imm));
        chk("bubble_cnt", 32'(ifc.bubble_cnt), 32'(sat(r.st.cnt, 65535)));
        chk("bubble_cnt_narrow", 32'(ifS.bubble_cnt), 32'(sat(r.st.cnt, 15)));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic doReset();
    #1;
    drive(idle());
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(ifc.ex_valid), 32'd0);
    chk("rst_ex_A", 32'(ifc.ex_A), 32'd0);
    chk("rst_ex_B", 32'(ifc.ex_B), 32'd0);
    chk("rst_ex_regs", 32'({ifc.ex_SrcReg1, ifc.ex_SrcReg2, ifc.ex_DstReg}), 32'd0);
    chk("rst_ex_ctrl", 32'({ifc.ex_RegWrite, ifc.ex_MemRead}), 32'd0);
    chk("rst_ex_imm", 32'(ifc.ex_imm), 32'd0);
    chk("rst_bubble_cnt", 32'(ifc.bubble_cnt), 32'd0);
    chk("rst_stall_id", 32'(ifc.stall_id), 32'd0);
    mdl = resetState();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : driver
    stim_t s;
    stim_t ld;
    logic st;
    int c0;
    mdl = resetState();
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Writeback bypass into a load edge
    step(idle(), st);
    s = idle(); s.inV = 1; s.u1 = 1; s.s1 = 3; s.d1 = 16'h1111;
    s.wbW = 1; s.wbD = 3; s.wbData = 16'hBEEF;
    step(s, st);
    chk("byp_wb_exA", 32'(ifc.ex_A), 32'h0000BEEF);
    s.wbW = 0;
    step(s, st);
    chk("byp_nowb_exA", 32'(ifc.ex_A), 32'h00001111);

    // Load-use hazard on SrcReg2
    ld = idle(); ld.inV = 1; ld.dst = 5; ld.rw = 1; ld.mr = 1; ld.s1 = 9; ld.s2 = 10;
    step(ld, st);
    c0 = mdl.cnt;
    s = idle(); s.inV = 1; s.s1 = 1; s.s2 = 5; s.u2 = 1; s.d2 = 16'h2222;
    s.wbW = 1; s.wbD = 5; s.wbData = 16'h5A5A;
    step(s, st);
    chk("luse_stall_id", 32'(st), 32'd1);
    chk("luse_bubble_valid", 32'(ifc.ex_valid), 32'd0);
    chk("luse_bubble_cnt", 32'(ifc.bubble_cnt), 32'(c0 + 1));
    step(s, st);
    chk("luse_resume_stall", 32'(st), 32'd0);
    chk("luse_resume_valid", 32'(ifc.ex_valid), 32'd1);
    chk("luse_resume_exB", 32'(ifc.ex_B), 32'h00005A5A);
    step(ld, st);
    s.u2 = 0;
    step(s, st);
    chk("nouse_stall_id", 32'(st), 32'd0);
    chk("nouse_valid", 32'(ifc.ex_valid), 32'd1);

    // Hold with refresh of ex_A from a writeback in the second stalled cycle
    s = idle(); s.inV = 1; s.u1 = 1; s.s1 = 7; s.d1 = 16'h0007; s.imm = 16'h1234;
    step(s, st);
    s = idle(); s.stallIn = 1;
    step(s, st);
    chk("hold1_exA", 32'(ifc.ex_A), 32'h00000007);
    s.wbW = 1; s.wbD = 7; s.wbData = 16'h00A5;
    step(s, st);
    chk("hold2_exA", 32'(ifc.ex_A), 32'h000000A5);
    chk("hold2_imm", 32'(ifc.ex_imm), 32'h00001234);
    chk("hold2_src1", 32'(ifc.ex_SrcReg1), 32'd7);
    s.wbW = 0;
    step(s, st);
    chk("hold3_stall_id", 32'(st), 32'd1);
    chk("hold3_exA", 32'(ifc.ex_A), 32'h000000A5);
    chk("hold3_valid", 32'(ifc.ex_valid), 32'd1);

    // Flush beats stall_in and load-use
    step(ld, st);
    c0 = mdl.cnt;
    s = idle(); s.inV = 1; s.u1 = 1; s.s1 = 5; s.stallIn = 1; s.flush = 1;
    step(s, st);
    chk("flush_stall_id", 32'(st), 32'd0);
    chk("flush_ctrl", 32'({ifc.ex_valid, ifc.ex_RegWrite, ifc.ex_MemRead}), 32'd0);
    chk("flush_bubble_cnt", 32'(ifc.bubble_cnt), 32'(c0));

    // Twenty guaranteed bubbles: the narrow counter must pin at its maximum
    for (int i = 0; i < 20; i++) begin
      step(ld, st);
      s = idle(); s.inV = 1; s.u1 = 1; s.s1 = 5;
      step(s, st);
    end
    chk("sat_narrow", 32'(ifS.bubble_cnt), 32'd15);

    // Asynchronous reset while a real instruction sits in the latch
    step(ld, st);
    chk("pre_rst_valid", 32'(ifc.ex_valid), 32'd1);
    doReset();

    for (int i = 0; i < 3000; i++) begin
      step(rndStim(), st);
      if (i == 1500) doReset();
    end

    drive(idle());
    repeat (2) @(negedge clk);
    nCmp++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
